// File: rtl/jogo_pkg.sv
// Shared definitions for the game controller: default board/map/shot limits,
// the FSM state encoding and a wrap-around increment helper.
package jogo_pkg;

  localparam int unsigned NUM_COLUNAS_DEF = 5;
  localparam int unsigned NUM_LINHAS_DEF  = 5;
  localparam int unsigned NUM_MAPAS_DEF   = 4;
  localparam int unsigned MAX_TIROS_DEF   = 10;

  // One-hot so each mode flag is a single register bit.
  typedef enum logic [2:0] {
    StDesligado  = 3'b001,
    StPreparacao = 3'b010,
    StAtaque     = 3'b100
  } estado_t;

  // Increment a 3-bit index, returning to 0 after the last legal value.
  function automatic logic [2:0] incr_wrap(input logic [2:0] valor, input logic [2:0] ultimo);
    return (valor == ultimo) ? 3'd0 : valor + 3'd1;
  endfunction

endpackage

// File: rtl/controle_jogo_if.sv
// Player-side bundle of the game controller.
//   inputs : chave_liga, btn_confirma, btn_coluna, btn_linha (asynchronous levels)
//   outputs: ATAQUE/PREPARACAO/DESLIGADO mode flags, coordColuna, coordLinha, mapa,
//            disparo strobe, tiros_restantes, fim_jogo
// master = the player/panel side, slave = the controller.
interface controle_jogo_if;

  logic       chave_liga;
  logic       btn_confirma;
  logic       btn_coluna;
  logic       btn_linha;
  logic       ATAQUE;
  logic       PREPARACAO;
  logic       DESLIGADO;
  logic [2:0] coordColuna;
  logic [2:0] coordLinha;
  logic [2:0] mapa;
  logic       disparo;
  logic [3:0] tiros_restantes;
  logic       fim_jogo;

  modport master (
    output chave_liga, btn_confirma, btn_coluna, btn_linha,
    input  ATAQUE, PREPARACAO, DESLIGADO, coordColuna, coordLinha, mapa,
    input  disparo, tiros_restantes, fim_jogo
  );

  modport slave (
    input  chave_liga, btn_confirma, btn_coluna, btn_linha,
    output ATAQUE, PREPARACAO, DESLIGADO, coordColuna, coordLinha, mapa,
    output disparo, tiros_restantes, fim_jogo
  );

endinterface

// File: rtl/detector_borda.sv
// Two-flop synchronizer followed by a rising-edge detector for one button.
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_btn          : asynchronous button level
//   o_pulso        : one-cycle pulse on each synchronized 0->1 transition
module detector_borda (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulso
);

  logic r_sinc1;
  logic r_sinc2;
  logic r_anterior;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sinc1    <= 1'b0;
      r_sinc2    <= 1'b0;
      r_anterior <= 1'b0;
    end else begin
      r_sinc1    <= i_btn;
      r_sinc2    <= r_sinc1;
      r_anterior <= r_sinc2;
    end
  end

  assign o_pulso = r_sinc2 & ~r_anterior;

endmodule

// File: rtl/controle_jogo.sv
// Game controller: power / map selection / attack FSM for a grid shooting game.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : switch and button inputs, mode flags, target coordinate,
//                    selected map, fire strobe, remaining shots and game-over flag
// All outputs come straight from registers.
module controle_jogo
  import jogo_pkg::*;
#(
  parameter int unsigned NUM_COLUNAS = NUM_COLUNAS_DEF,
  parameter int unsigned NUM_LINHAS  = NUM_LINHAS_DEF,
  parameter int unsigned NUM_MAPAS   = NUM_MAPAS_DEF,
  parameter int unsigned MAX_TIROS   = MAX_TIROS_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  controle_jogo_if.slave  bus
);

  localparam logic [2:0] UltColuna = 3'(NUM_COLUNAS - 1);
  localparam logic [2:0] UltLinha  = 3'(NUM_LINHAS - 1);
  localparam logic [2:0] UltMapa   = 3'(NUM_MAPAS - 1);
  localparam logic [3:0] TirosIni  = 4'(MAX_TIROS);

  logic    r_chave_s1;
  logic    r_chave_s2;
  logic    w_p_confirma;
  logic    w_p_coluna;
  logic    w_p_linha;

  estado_t    r_estado;
  logic [2:0] r_coluna;
  logic [2:0] r_linha;
  logic [2:0] r_mapa;
  logic       r_disparo;
  logic [3:0] r_tiros;
  logic       r_fim;

  // The power switch is a level, so it only needs synchronizing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_chave_s1 <= 1'b0;
      r_chave_s2 <= 1'b0;
    end else begin
      r_chave_s1 <= bus.chave_liga;
      r_chave_s2 <= r_chave_s1;
    end
  end

  detector_borda u_borda_confirma (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_btn   (bus.btn_confirma),
    .o_pulso (w_p_confirma)
  );

  detector_borda u_borda_coluna (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_btn   (bus.btn_coluna),
    .o_pulso (w_p_coluna)
  );

  detector_borda u_borda_linha (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_btn   (bus.btn_linha),
    .o_pulso (w_p_linha)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado  <= StDesligado;
      r_coluna  <= 3'd0;
      r_linha   <= 3'd0;
      r_mapa    <= 3'd0;
      r_disparo <= 1'b0;
      r_tiros   <= 4'd0;
      r_fim     <= 1'b0;
    end else begin
      r_disparo <= 1'b0;
      // Switching off overrides every button pulse.
      if (!r_chave_s2) begin
        r_estado <= StDesligado;
        r_coluna <= 3'd0;
        r_linha  <= 3'd0;
        r_mapa   <= 3'd0;
        r_tiros  <= 4'd0;
        r_fim    <= 1'b0;
      end else begin
        unique case (r_estado)
          StDesligado: r_estado <= StPreparacao;
          StPreparacao: begin
            if (w_p_confirma) begin
              r_estado <= StAtaque;
              r_tiros  <= TirosIni;
              r_coluna <= 3'd0;
              r_linha  <= 3'd0;
              r_fim    <= 1'b0;
            end else if (w_p_coluna) begin
              r_mapa <= incr_wrap(r_mapa, UltMapa);
            end
          end
          StAtaque: begin
            // A confirm pulse swallows any coordinate pulse in the same cycle.
            if (w_p_confirma) begin
              if (r_tiros != 4'd0) begin
                r_disparo <= 1'b1;
                r_tiros   <= r_tiros - 4'd1;
                r_fim     <= (r_tiros == 4'd1);
              end
            end else begin
              if (w_p_coluna) r_coluna <= incr_wrap(r_coluna, UltColuna);
              if (w_p_linha)  r_linha  <= incr_wrap(r_linha, UltLinha);
            end
          end
          default: r_estado <= StDesligado;
        endcase
      end
    end
  end

  assign bus.DESLIGADO       = (r_estado == StDesligado);
  assign bus.PREPARACAO      = (r_estado == StPreparacao);
  assign bus.ATAQUE          = (r_estado == StAtaque);
  assign bus.coordColuna     = r_coluna;
  assign bus.coordLinha      = r_linha;
  assign bus.mapa            = r_mapa;
  assign bus.disparo         = r_disparo;
  assign bus.tiros_restantes = r_tiros;
  assign bus.fim_jogo        = r_fim;

endmodule

// File: doc/controle_jogo.md
CONTROLE_JOGO -- requirements
Module: controle_jogo

Interface
REQ-001 SHALL have parameter NUM_COLUNAS, default 5, the number of board columns (legal 1..8).
REQ-002 SHALL have parameter NUM_LINHAS, default 5, the number of board rows (legal 1..8).
REQ-003 SHALL have parameter NUM_MAPAS, default 4, the number of selectable maps (legal 1..8).
REQ-004 SHALL have parameter MAX_TIROS, default 10, the shots per game (legal 1..15).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clock  input  1  system clock; all state updates on the rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 chave_liga  input  1  power switch level, asynchronous, 1=on.
REQ-009 btn_confirma  input  1  confirm/fire button, asynchronous, active-high, debounced externally.
REQ-010 btn_coluna  input  1  column/map advance button, asynchronous, active-high, debounced externally.
REQ-011 btn_linha  input  1  row advance button, asynchronous, active-high, debounced externally.
REQ-012 ATAQUE, PREPARACAO, DESLIGADO  output  1 each  one-hot mode flags for the display.
REQ-013 coordColuna, coordLinha  output  3 each  current target coordinate.
REQ-014 mapa  output  3  selected map index.
REQ-015 disparo  output  1  one-cycle fire strobe.
REQ-016 tiros_restantes  output  4  shots remaining.
REQ-017 fim_jogo  output  1  high when tiros_restantes==0 in ATAQUE.

Function
REQ-018 SHALL pass each of the four asynchronous inputs through a 2-flop synchronizer; each button SHALL then produce a one-cycle rising-edge pulse, and a held button SHALL produce exactly one pulse.
REQ-019 Latency: an effect SHALL be visible on outputs exactly 3 rising edges after the first edge that samples the new input level.
REQ-020 SHALL implement FSM states DESLIGADO, PREPARACAO and ATAQUE; exactly one mode flag SHALL be high at all times.
REQ-021 From any state, synchronized chave_liga==0 SHALL move to DESLIGADO and clear mapa, coordinates, tiros_restantes and fim_jogo; this SHALL take priority over all button pulses.
REQ-022 In DESLIGADO, synchronized chave_liga==1 SHALL move to PREPARACAO; all button pulses SHALL be ignored.
REQ-023 In PREPARACAO, a btn_coluna pulse SHALL increment mapa, wrapping from NUM_MAPAS-1 to 0; btn_linha SHALL be ignored.
REQ-024 In PREPARACAO, a btn_confirma pulse SHALL move to ATAQUE, load tiros_restantes=MAX_TIROS, and set both coordinates to 0; mapa SHALL be held.
REQ-025 In ATAQUE, a btn_coluna pulse SHALL increment coordColuna, wrapping from NUM_COLUNAS-1 to 0; btn_linha SHALL do the same for coordLinha against NUM_LINHAS-1; both MAY occur in the same cycle.
REQ-026 In ATAQUE, a btn_confirma pulse with tiros_restantes>0 SHALL assert disparo for exactly one cycle and decrement tiros_restantes on the same edge; coordinates SHALL be unchanged in that cycle.
REQ-027 When btn_confirma and btn_coluna/btn_linha pulse together in ATAQUE, confirm SHALL win and the coordinate pulses SHALL be dropped.
REQ-028 With tiros_restantes==0, btn_confirma SHALL produce no disparo; fim_jogo SHALL be 1; coordinate buttons remain active.
REQ-029 ATAQUE SHALL be left only via chave_liga==0 or reset.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs.

Reset
REQ-031 reset_n low SHALL immediately force the state to DESLIGADO (DESLIGADO=1, others 0), coordinates=0, mapa=0, disparo=0, tiros_restantes=0, fim_jogo=0, and clear the synchronizer and edge flops.
REQ-032 Reset deassertion with chave_liga=1 SHALL reach PREPARACAO 3 edges later; a held button SHALL NOT produce a pulse after reset.

Structure
REQ-033 State encoding and the default parameter values SHALL live in the shared package jogo_pkg.
REQ-034 The synchronizer and edge detector SHALL be sub-module detector_borda, instantiated 3 times; chave_liga SHALL use the synchronizer only.

Verification
REQ-035 Reset, chave_liga=1 -> PREPARACAO=1 at edge 3; press btn_coluna 5x -> mapa sequence 1,2,3,0,1.
REQ-036 Confirm in PREPARACAO -> ATAQUE=1, tiros_restantes=10, coordColuna=coordLinha=0.
REQ-037 In ATAQUE, press btn_coluna 6x and btn_linha 2x -> coordColuna=1, coordLinha=2; a simultaneous column+linha press -> both increment.
REQ-038 Fire 11x -> 10 one-cycle disparo pulses, tiros_restantes 10..0, fim_jogo=1, 11th press gives no disparo; confirm+coluna together -> disparo with coordinates unchanged.
REQ-039 Hold btn_confirma for 50 cycles -> exactly one disparo.
REQ-040 chave_liga=0 mid-ATAQUE, and separately reset_n pulsed mid-ATAQUE -> DESLIGADO=1 with all counters 0; buttons ignored until chave_liga=1.
